// File: rtl/encoder_4to2.sv
// Registered priority encoder: index of the highest set bit of in, plus valid.
// Define ENCODER_ONEHOT_CHECK_EN to add err, flagging inputs with more than one bit set.
module encoder_4to2 #(
  parameter int IN_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [IN_W-1:0]           in,
  output logic [$clog2(IN_W)-1:0]   out,
  output logic                      valid
`ifdef ENCODER_ONEHOT_CHECK_EN
  ,
  output logic                      err
`endif
);

  localparam int OUT_W = $clog2(IN_W);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;

  // Ascending scan: later (higher) set bits overwrite earlier ones, so the MSB wins.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in[i]) begin
        w_idx = OUT_W'(i);
      end
    end
  end

  assign w_any = |in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_out   <= w_idx;
      r_valid <= w_any;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic w_multi;
  logic r_err;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = (in & (in - IN_W'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (en) begin
      r_err <= w_multi;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
// Scoreboard bench for encoder_4to2: default width instance plus an 8-bit instance.
module tb_encoder_4to2;

  typedef struct {
    logic [2:0] o;
    logic       v;
    logic       e;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] in  = 4'h0;
  logic [1:0] out;
  logic       valid;
  logic [7:0] in8 = 8'h00;
  logic [2:0] out8;
  logic       valid8;
  logic       err;
  logic       err8;

  int tests  = 0;
  int failed = 0;
  int txn    = 0;

  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;

`ifdef ENCODER_ONEHOT_CHECK_EN
  encoder_4to2 dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(out), .valid(valid), .err(err)
  );
  encoder_4to2 #(.IN_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(1'b1), .in(in8), .out(out8), .valid(valid8), .err(err8)
  );
`else
  encoder_4to2 dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(out), .valid(valid)
  );
  encoder_4to2 #(.IN_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(1'b1), .in(in8), .out(out8), .valid(valid8)
  );
  assign err  = 1'b0;
  assign err8 = 1'b0;
`endif

  // Inputs change at negedge; the expectation is queued for the following posedge.
  task automatic step(input logic r, input logic e, input logic [3:0] v,
                      input logic [1:0] eo, input logic ev, input logic ee);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; in = v;
    x.o = {1'b0, eo}; x.v = ev; x.e = ee; x.id = txn;
    txn++;
    q4.push_back(x);
  endtask

  task automatic step8(input logic [7:0] v, input logic [2:0] eo, input logic ev,
                       input logic ee);
    exp_t x;
    @(negedge clk);
    rst = 1'b0; in8 = v;
    x.o = eo; x.v = ev; x.e = ee; x.id = txn;
    txn++;
    q8.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    logic ok;
    #1;
    if (q4.size() != 0) begin
      x = q4.pop_front();
      ok = (out == x.o[1:0]) && (valid == x.v);
`ifdef ENCODER_ONEHOT_CHECK_EN
      ok = ok && (err == x.e);
`endif
      tests++;
      if (!ok) begin
        failed++;
        $display("[TB] FAIL enc4 txn %0d: got out=%b valid=%b err=%b, want out=%b valid=%b err=%b",
                 x.id, out, valid, err, x.o[1:0], x.v, x.e);
      end else begin
        $display("[TB] ok enc4 txn %0d: out=%b valid=%b err=%b", x.id, out, valid, err);
      end
    end
    if (q8.size() != 0) begin
      x = q8.pop_front();
      ok = (out8 == x.o) && (valid8 == x.v);
`ifdef ENCODER_ONEHOT_CHECK_EN
      ok = ok && (err8 == x.e);
`endif
      tests++;
      if (!ok) begin
        failed++;
        $display("[TB] FAIL enc8 txn %0d: got out=%b valid=%b err=%b, want out=%b valid=%b err=%b",
                 x.id, out8, valid8, err8, x.o, x.v, x.e);
      end else begin
        $display("[TB] ok enc8 txn %0d: out=%b valid=%b err=%b", x.id, out8, valid8, err8);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    // Reset held two edges with active-looking input, then release.
    step(1, 1, 4'b1111, 2'b00, 0, 0);
    step(1, 1, 4'b1111, 2'b00, 0, 0);
    step(0, 1, 4'b1111, 2'b11, 1, 1);
    // One-hot and zero.
    step(0, 1, 4'b0000, 2'b00, 0, 0);
    step(0, 1, 4'b0001, 2'b00, 1, 0);
    step(0, 1, 4'b0010, 2'b01, 1, 0);
    step(0, 1, 4'b0100, 2'b10, 1, 0);
    step(0, 1, 4'b1000, 2'b11, 1, 0);
    // Multi-hot.
    step(0, 1, 4'b0110, 2'b10, 1, 1);
    step(0, 1, 4'b1011, 2'b11, 1, 1);
    step(0, 1, 4'b0011, 2'b01, 1, 1);
    step(0, 1, 4'b0101, 2'b10, 1, 1);
    // Hold while disabled.
    step(0, 1, 4'b0100, 2'b10, 1, 0);
    step(0, 0, 4'b0001, 2'b10, 1, 0);
    step(0, 0, 4'b0001, 2'b10, 1, 0);
    step(0, 0, 4'b0001, 2'b10, 1, 0);
    step(0, 1, 4'b0001, 2'b00, 1, 0);
    // Hold of a multi-hot result, including err.
    step(0, 1, 4'b1100, 2'b11, 1, 1);
    step(0, 0, 4'b0000, 2'b11, 1, 1);
    // Mid-stream reset.
    step(0, 1, 4'b1000, 2'b11, 1, 0);
    step(1, 1, 4'b1000, 2'b00, 0, 0);
    step(0, 1, 4'b1000, 2'b11, 1, 0);
    // Reset overrides en=0, then disabled hold keeps the cleared state.
    step(1, 0, 4'b1111, 2'b00, 0, 0);
    step(0, 0, 4'b1111, 2'b00, 0, 0);
    step(0, 1, 4'b1111, 2'b11, 1, 1);
    // 8-bit instance.
    step8(8'b0010_0000, 3'b101, 1, 0);
    step8(8'b0000_0000, 3'b000, 0, 0);
    step8(8'b1000_0000, 3'b111, 1, 0);
    step8(8'b0000_0001, 3'b000, 1, 0);
    step8(8'b0101_0000, 3'b110, 1, 1);
    step8(8'b0000_1100, 3'b011, 1, 1);

    budget = 20;
    while ((q4.size() != 0 || q8.size() != 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (q4.size() != 0 || q8.size() != 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain: %0d/%0d expectations left, want 0", q4.size(), q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/encoder_4to2.md
Name: encoder_4to2

Overview:
- Registered priority encoder: converts a 4-bit request vector into the 2-bit binary index of its highest set bit.
- Also produces a valid flag when any bit is set.
- Used wherever a one-hot or few-hot select/request vector must be compressed to an index, e.g. arbiter grant encoding or mux-select generation.
- Single clock domain; all outputs registered, one-cycle latency.

Parameters:
- IN_W, default 4: input vector width. Must be a power of two and at least 2. The default gives the 4-to-2 configuration.
- OUT_W, default $clog2(IN_W) (2 at default): output index width. Derived; must not be overridden independently.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  sample enable; when 0, all output registers hold.
- in  input  IN_W  request vector.
- out  output  OUT_W  registered index of the highest set bit of in.
- valid  output  1  registered; 1 when the sampled in was non-zero.

Behaviour:
- Reset: at a clk edge with rst=1, out=0, valid=0 (and err=0 when the optional feature is compiled in). rst overrides en.
- At a clk edge with rst=0, en=1, the block samples in and updates outputs; new values are visible after that edge (latency 1 cycle). Throughput: 1 per cycle.
- At a clk edge with rst=0, en=0, all outputs hold their previous values.
- Encoding: out = index of the most-significant 1 in in (bit IN_W-1 has highest priority).
- At default width: 0001→00, 0010→01, 0100→10, 1000→11.
- Multi-hot input: the highest bit wins, e.g. 0110→10 and 1111→11.
- Zero input: out=0, valid=0. The value 00 with valid=0 distinguishes "no request" from in=0001 (out=00, valid=1).
- Input X/Z handling is not required; inputs are assumed driven.
- The encoder logic is purely combinational ahead of the output register, with no internal state beyond the output registers.
- Reset asserted mid-stream clears outputs on that edge regardless of in or en. The first sample after deassertion follows normal rules.

Optional Feature:
- Macro: ENCODER_ONEHOT_CHECK_EN.
- Defined:
  - Adds port err (output, 1 bit), registered alongside out and valid with the same en/rst rules.
  - err=1 when the sampled in has more than one bit set; e.g. 0110→err=1, 0100→err=0, 0000→err=0.
  - out and valid are unaffected (priority encoding still applies).
- Undefined: err port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Hold rst=1 for 2 cycles with in=1111, en=1 → out=00, valid=0 (err=0) after each edge; release rst → next edge out=11, valid=1.
- en=1, drive in=0000, 0001, 0010, 0100, 1000 on successive cycles → one cycle later out = 00/v0, 00/v1, 01/v1, 10/v1, 11/v1 respectively.
- en=1, drive in=0110, 1011, 0011 → out=10, 11, 01, all valid=1. With ENCODER_ONEHOT_CHECK_EN, err=1 for each; with in=0100, err=0.
- Load in=0100 with en=1 (out=10), then en=0 and change in to 0001 for 3 cycles → out stays 10, valid stays 1. Re-enable → out=00, valid=1 on the next edge.
- With in=1000, en=1 streaming, assert rst for one cycle → outputs 00/0 at that edge; following edge out=11, valid=1.
- Parameter check: IN_W=8, in=8'b0010_0000 → out=3'b101, valid=1; in=0 → valid=0.
